// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pkg
//  Purpose  : Shared array geometry and controller state encoding for the
//             weight-stationary systolic array sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package systolic_pkg;

    localparam int SA_N  = 4;   // rows = columns of the array
    localparam int SA_DW = 32;  // weight / input element width
    localparam int SA_CW = 16;  // vector counter width

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        SWITCH = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/systolic_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_ctrl_if
//  Purpose  : Control, weight stream, input stream and array-side signals of
//             the systolic sequencer. master = sequencer, slave = environment.
//  Revision : 1.0  initial release
// ============================================================================
interface systolic_ctrl_if
    import systolic_pkg::*;
#(
    parameter int N  = SA_N,
    parameter int DW = SA_DW,
    parameter int CW = SA_CW
);
    logic            ctrl_start;
    logic [CW-1:0]   ctrl_num_vec;
    logic            ctrl_busy;
    logic            ctrl_done;
    logic            w_valid;
    logic            w_ready;
    logic [N*DW-1:0] w_data;
    logic            x_valid;
    logic            x_ready;
    logic [N*DW-1:0] x_data;
    logic [N*DW-1:0] sys_weight;
    logic [N-1:0]    sys_accept_w;
    logic            sys_switch;
    logic [N*DW-1:0] sys_data;
    logic [N-1:0]    sys_start;
    logic [N-1:0]    sys_valid_in;

    modport master (
        input  ctrl_start, ctrl_num_vec, w_valid, w_data, x_valid, x_data, sys_valid_in,
        output ctrl_busy, ctrl_done, w_ready, x_ready,
               sys_weight, sys_accept_w, sys_switch, sys_data, sys_start
    );

    modport slave (
        output ctrl_start, ctrl_num_vec, w_valid, w_data, x_valid, x_data, sys_valid_in,
        input  ctrl_busy, ctrl_done, w_ready, x_ready,
               sys_weight, sys_accept_w, sys_switch, sys_data, sys_start
    );

endinterface
`default_nettype wire

// File: rtl/input_skew.sv
`default_nettype none
// ============================================================================
//  Module   : input_skew
//  Purpose  : Triangular delay line giving the diagonal skew of the input
//             wavefront; lane i carries data+start through i register stages.
//  Revision : 1.0  initial release
// ============================================================================
module input_skew #(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic [N*DW-1:0] i_data,
    input  wire logic [N-1:0]    i_start,
    output logic      [N*DW-1:0] o_data,
    output logic      [N-1:0]    o_start
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_pass
            assign o_data[DW-1:0] = i_data[DW-1:0];
            assign o_start[0]     = i_start[0];
        end else begin : g_dly
            logic [DW-1:0] r_data [i];
            logic [i-1:0]  r_start;

            // Shift this lane's element and start flag down an i-deep pipe
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < i; k++) r_data[k] <= '0;
                    r_start <= '0;
                end else begin
                    r_data[0]  <= i_data[i*DW +: DW];
                    r_start[0] <= i_start[i];
                    for (int k = 1; k < i; k++) begin
                        r_data[k]  <= r_data[k-1];
                        r_start[k] <= r_start[k-1];
                    end
                end
            end

            assign o_data[i*DW +: DW] = r_data[i-1];
            assign o_start[i]         = r_start[i-1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_ctrl
//  Purpose  : Job sequencer for the weight-stationary systolic array: loads a
//             weight tile, switches shadow->active, streams skewed input
//             vectors and counts results leaving the last column.
//  Revision : 1.0  initial release
// ============================================================================
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int SYSTOLIC_ARRAY_WIDTH = SA_N,
    parameter int DATA_WIDTH           = SA_DW,
    parameter int CNT_WIDTH            = SA_CW
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    systolic_ctrl_if.master bus
);

    localparam int c_N      = SYSTOLIC_ARRAY_WIDTH;
    localparam int c_DW     = DATA_WIDTH;
    localparam int c_CW     = CNT_WIDTH;
    localparam int c_BEAT_W = $clog2(c_N + 1);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_N - 1);

    ctrl_state_e           r_state;
    logic [c_CW-1:0]       r_num_vec;
    logic [c_BEAT_W-1:0]   r_beat_cnt;
    logic [c_CW-1:0]       r_issue_cnt;
    logic [c_CW-1:0]       r_res_cnt;
    logic                  r_done;
    logic                  r_switch;
    logic [c_N*c_DW-1:0]   r_weight;
    logic [c_N-1:0]        r_accept_w;
    logic [c_N*c_DW-1:0]   r_x_data;
    logic                  r_x_start;

    logic w_w_ready;
    logic w_x_ready;
    logic w_w_fire;
    logic w_x_fire;
    logic w_count_res;
    logic w_unused_valid;

    // Ready depends only on state and counters, never on the valids
    assign w_w_ready   = (r_state == LOAD_W) && (r_beat_cnt < c_BEAT_W'(c_N));
    assign w_x_ready   = (r_state == STREAM) && (r_issue_cnt < r_num_vec);
    assign w_w_fire    = w_w_ready && bus.w_valid;
    assign w_x_fire    = w_x_ready && bus.x_valid;
    assign w_count_res = ((r_state == STREAM) || (r_state == DRAIN)) &&
                         bus.sys_valid_in[c_N-1] && (r_res_cnt < r_num_vec);

    // Only the last column's valid marks a completed result vector
    assign w_unused_valid = ^bus.sys_valid_in[c_N-2:0];

    // Sequencer FSM with its counters and registered array-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_num_vec   <= '0;
            r_beat_cnt  <= '0;
            r_issue_cnt <= '0;
            r_res_cnt   <= '0;
            r_done      <= 1'b0;
            r_switch    <= 1'b0;
            r_weight    <= '0;
            r_accept_w  <= '0;
            r_x_data    <= '0;
            r_x_start   <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_switch   <= 1'b0;
            r_weight   <= w_w_fire ? bus.w_data : '0;
            r_accept_w <= {c_N{w_w_fire}};
            r_x_data   <= w_x_fire ? bus.x_data : '0;
            r_x_start  <= w_x_fire;
            if (w_count_res) r_res_cnt <= r_res_cnt + 1'b1;

            case (r_state)
                IDLE: begin
                    if (bus.ctrl_start) begin
                        r_num_vec   <= bus.ctrl_num_vec;
                        r_beat_cnt  <= '0;
                        r_issue_cnt <= '0;
                        r_res_cnt   <= '0;
                        r_state     <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (w_w_fire) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == c_LAST_BEAT) r_state <= SWITCH;
                    end
                end
                SWITCH: begin
                    // Lands one cycle after the final accept_w pulse
                    r_switch <= 1'b1;
                    if (r_num_vec == '0) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_x_fire) begin
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                        if (r_issue_cnt == r_num_vec - 1'b1) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_res_cnt == r_num_vec) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    input_skew #(
        .N  (c_N),
        .DW (c_DW)
    ) u_skew (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (r_x_data),
        .i_start ({c_N{r_x_start}}),
        .o_data  (bus.sys_data),
        .o_start (bus.sys_start)
    );

    assign bus.ctrl_busy    = (r_state != IDLE);
    assign bus.ctrl_done    = r_done;
    assign bus.w_ready      = w_w_ready;
    assign bus.x_ready      = w_x_ready;
    assign bus.sys_weight   = r_weight;
    assign bus.sys_accept_w = r_accept_w;
    assign bus.sys_switch   = r_switch;

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_ctrl
//  Purpose  : Self-checking bench for systolic_ctrl: a cycle table for a full
//             job plus directed sequences for handshake gaps, bubbles, empty
//             jobs, start-while-busy and mid-job reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_systolic_ctrl;

    localparam int c_N  = 4;
    localparam int c_DW = 32;
    localparam int c_CW = 16;
    localparam int c_NV = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    systolic_ctrl_if #(.N(c_N), .DW(c_DW), .CW(c_CW)) bus ();

    systolic_ctrl #(
        .SYSTOLIC_ARRAY_WIDTH (c_N),
        .DATA_WIDTH           (c_DW),
        .CNT_WIDTH            (c_CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit        s;    int nv;  bit wv;  int wb;  bit xv;  int xb;  bit [3:0] vin;
        bit        busy; bit done; bit wr;  bit xr;  bit [3:0] acc; bit sw;
        int        ewb;  bit [3:0] st;  bit [7:0] lv;
    } vec_t;

    vec_t tv [c_NV];

    function automatic vec_t mk(bit s, int nv, bit wv, int wb, bit xv, int xb, bit [3:0] vin,
                                bit busy, bit done, bit wr, bit xr, bit [3:0] acc, bit sw,
                                int ewb, bit [3:0] st, bit [7:0] lv);
        vec_t v;
        v.s = s; v.nv = nv; v.wv = wv; v.wb = wb; v.xv = xv; v.xb = xb; v.vin = vin;
        v.busy = busy; v.done = done; v.wr = wr; v.xr = xr; v.acc = acc; v.sw = sw;
        v.ewb = ewb; v.st = st; v.lv = lv;
        return v;
    endfunction

    // Weight beat b: element j = B000_00bj
    function automatic logic [127:0] wdata(int b);
        logic [127:0] r;
        for (int j = 0; j < c_N; j++) r[j*32 +: 32] = 32'hB000_0000 + 32'(b * 16 + j);
        return r;
    endfunction

    // Input vector k: element i = A000_0k0i
    function automatic logic [127:0] xdata(int k);
        logic [127:0] r;
        for (int i = 0; i < c_N; i++) r[i*32 +: 32] = 32'hA000_0000 + 32'(k * 256 + i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_job(input int nv);
        bus.ctrl_start   = 1'b1;
        bus.ctrl_num_vec = 16'(nv);
        @(negedge clk);
        bus.ctrl_start   = 1'b0;
        bus.ctrl_num_vec = '0;
    endtask

    task automatic load_weights();
        for (int b = 0; b < c_N; b++) begin
            bus.w_valid = 1'b1;
            bus.w_data  = wdata(b);
            @(negedge clk);
        end
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
    endtask

    task automatic wait_x_ready(input string name);
        int k = 0;
        while (!bus.x_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk(name, bus.x_ready, 1'b1);
    endtask

    task automatic stream_vecs(input int n);
        wait_x_ready("x_ready_rise");
        for (int k = 0; k < n; k++) begin
            bus.x_valid = 1'b1;
            bus.x_data  = xdata(k);
            @(negedge clk);
        end
        bus.x_valid = 1'b0;
        bus.x_data  = '0;
    endtask

    task automatic feed_results(input int n);
        for (int k = 0; k < n; k++) begin
            bus.sys_valid_in = 4'b1000;
            @(negedge clk);
        end
        bus.sys_valid_in = '0;
    endtask

    // Count done pulses over a fixed window and expect the job to end idle
    task automatic wait_done(input string name);
        int cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.ctrl_done) cnt++;
            @(negedge clk);
        end
        chk({name, "_done_count"}, 128'(cnt), 128'd1);
        chk({name, "_idle"}, bus.ctrl_busy, 1'b0);
    endtask

    initial begin
        logic [127:0] exp_w;
        logic [127:0] exp_d;
        logic [127:0] tmp;
        bit   [3:0]   s0_seq;
        bit   [3:0]   s3_seq;
        int           cnt;
        bit           seen;

        bus.ctrl_start = 1'b0; bus.ctrl_num_vec = '0;
        bus.w_valid = 1'b0; bus.w_data = '0;
        bus.x_valid = 1'b0; bus.x_data = '0;
        bus.sys_valid_in = '0;

        // Test 1 cycle table: num_vec=3, back-to-back weights and vectors
        tv[0]  = mk(1,3, 0,0, 0,0, 4'b0000, 0,0,0,0, 4'h0,0,-1, 4'b0000, 8'h00);
        tv[1]  = mk(0,0, 1,0, 0,0, 4'b0000, 1,0,1,0, 4'h0,0,-1, 4'b0000, 8'h00);
        tv[2]  = mk(0,0, 1,1, 0,0, 4'b0000, 1,0,1,0, 4'hF,0, 0, 4'b0000, 8'h00);
        tv[3]  = mk(0,0, 1,2, 0,0, 4'b0000, 1,0,1,0, 4'hF,0, 1, 4'b0000, 8'h00);
        tv[4]  = mk(0,0, 1,3, 0,0, 4'b0000, 1,0,1,0, 4'hF,0, 2, 4'b0000, 8'h00);
        tv[5]  = mk(0,0, 0,0, 0,0, 4'b0000, 1,0,0,0, 4'hF,0, 3, 4'b0000, 8'h00);
        tv[6]  = mk(0,0, 0,0, 1,0, 4'b0000, 1,0,0,1, 4'h0,1,-1, 4'b0000, 8'h00);
        tv[7]  = mk(0,0, 0,0, 1,1, 4'b0000, 1,0,0,1, 4'h0,0,-1, 4'b0001, 8'b00_00_00_00);
        tv[8]  = mk(0,0, 0,0, 1,2, 4'b0000, 1,0,0,1, 4'h0,0,-1, 4'b0011, 8'b00_00_00_01);
        tv[9]  = mk(0,0, 0,0, 0,0, 4'b0000, 1,0,0,0, 4'h0,0,-1, 4'b0111, 8'b00_00_01_10);
        tv[10] = mk(0,0, 0,0, 0,0, 4'b0000, 1,0,0,0, 4'h0,0,-1, 4'b1110, 8'b00_01_10_00);
        tv[11] = mk(0,0, 0,0, 0,0, 4'b0111, 1,0,0,0, 4'h0,0,-1, 4'b1100, 8'b01_10_00_00);
        tv[12] = mk(0,0, 0,0, 0,0, 4'b1000, 1,0,0,0, 4'h0,0,-1, 4'b1000, 8'b10_00_00_00);
        tv[13] = mk(0,0, 0,0, 0,0, 4'b1000, 1,0,0,0, 4'h0,0,-1, 4'b0000, 8'h00);
        tv[14] = mk(0,0, 0,0, 0,0, 4'b1000, 1,0,0,0, 4'h0,0,-1, 4'b0000, 8'h00);
        tv[15] = mk(0,0, 0,0, 0,0, 4'b0000, 1,0,0,0, 4'h0,0,-1, 4'b0000, 8'h00);
        tv[16] = mk(0,0, 0,0, 0,0, 4'b1000, 0,1,0,0, 4'h0,0,-1, 4'b0000, 8'h00);
        tv[17] = mk(0,0, 0,0, 0,0, 4'b0000, 0,0,0,0, 4'h0,0,-1, 4'b0000, 8'h00);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy",   bus.ctrl_busy,    1'b0);
        chk("rst_done",   bus.ctrl_done,    1'b0);
        chk("rst_wready", bus.w_ready,      1'b0);
        chk("rst_xready", bus.x_ready,      1'b0);
        chk("rst_acc",    bus.sys_accept_w, 4'h0);
        chk("rst_sw",     bus.sys_switch,   1'b0);
        chk("rst_start",  bus.sys_start,    4'h0);
        chk("rst_data",   bus.sys_data,     '0);
        rst_n = 1'b1;

        // Test 1: table-driven full job
        for (int i = 0; i < c_NV; i++) begin
            chk($sformatf("t1_v%0d_busy", i),  bus.ctrl_busy,    tv[i].busy);
            chk($sformatf("t1_v%0d_done", i),  bus.ctrl_done,    tv[i].done);
            chk($sformatf("t1_v%0d_wrdy", i),  bus.w_ready,      tv[i].wr);
            chk($sformatf("t1_v%0d_xrdy", i),  bus.x_ready,      tv[i].xr);
            chk($sformatf("t1_v%0d_acc", i),   bus.sys_accept_w, tv[i].acc);
            chk($sformatf("t1_v%0d_sw", i),    bus.sys_switch,   tv[i].sw);
            exp_w = (tv[i].ewb < 0) ? '0 : wdata(tv[i].ewb);
            chk($sformatf("t1_v%0d_wt", i),    bus.sys_weight,   exp_w);
            chk($sformatf("t1_v%0d_start", i), bus.sys_start,    tv[i].st);
            exp_d = '0;
            for (int l = 0; l < c_N; l++) begin
                if (tv[i].st[l]) begin
                    tmp = xdata(int'(tv[i].lv[2*l +: 2]));
                    exp_d[l*32 +: 32] = tmp[l*32 +: 32];
                end
            end
            chk($sformatf("t1_v%0d_data", i),  bus.sys_data,     exp_d);
            bus.ctrl_start   = tv[i].s;
            bus.ctrl_num_vec = 16'(tv[i].nv);
            bus.w_valid      = tv[i].wv;
            bus.w_data       = tv[i].wv ? wdata(tv[i].wb) : '0;
            bus.x_valid      = tv[i].xv;
            bus.x_data       = tv[i].xv ? xdata(tv[i].xb) : '0;
            bus.sys_valid_in = tv[i].vin;
            @(negedge clk);
        end
        bus.ctrl_start = 1'b0; bus.w_valid = 1'b0; bus.x_valid = 1'b0; bus.sys_valid_in = '0;

        // Test 2: alternating w_valid, accept_w mirrors handshakes
        start_job(1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t2_acc_%0d", k), bus.sys_accept_w, {4{k[0]}});
            chk($sformatf("t2_sw_%0d", k),  bus.sys_switch,   1'b0);
            if (k == 3) chk("t2_wt_beat1", bus.sys_weight, wdata(1));
            bus.w_valid = (k % 2 == 0);
            bus.w_data  = (k % 2 == 0) ? wdata(k / 2) : '0;
            @(negedge clk);
        end
        chk("t2_acc_8", bus.sys_accept_w, 4'h0);
        chk("t2_sw_8",  bus.sys_switch,   1'b1);
        stream_vecs(1);
        feed_results(1);
        wait_done("t2");

        // Test 3: bubble between vector 0 and vector 1
        start_job(2);
        load_weights();
        wait_x_ready("t3_xrdy");
        bus.x_valid = 1'b1; bus.x_data = xdata(0);
        @(negedge clk);
        s0_seq = '0; s3_seq = '0;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 3) s0_seq[k-1] = bus.sys_start[0];
            if (k >= 4) s3_seq[k-4] = bus.sys_start[3];
            if (k == 6) begin
                tmp = xdata(1);
                chk("t3_lane3_data", bus.sys_data[127:96], tmp[127:96]);
            end
            if (k == 2) begin
                chk("t3_xrdy_gap", bus.x_ready, 1'b1);
                bus.x_valid = 1'b1; bus.x_data = xdata(1);
            end else begin
                bus.x_valid = 1'b0; bus.x_data = '0;
            end
            @(negedge clk);
        end
        chk("t3_start0_seq", s0_seq, 4'b0101);
        chk("t3_start3_seq", s3_seq, 4'b0101);
        feed_results(2);
        wait_done("t3");

        // Test 4: num_vec = 0 finishes right after the switch
        start_job(0);
        load_weights();
        cnt = 0; seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus.ctrl_done) cnt++;
            if (bus.x_ready)   seen = 1'b1;
            @(negedge clk);
        end
        chk("t4_done_count", 128'(cnt), 128'd1);
        chk("t4_xready_seen", seen, 1'b0);
        chk("t4_idle", bus.ctrl_busy, 1'b0);

        // Test 5: start while streaming is ignored
        start_job(2);
        load_weights();
        wait_x_ready("t5_xrdy");
        bus.x_valid = 1'b1; bus.x_data = xdata(0);
        bus.ctrl_start = 1'b1; bus.ctrl_num_vec = 16'd7;
        @(negedge clk);
        bus.ctrl_start = 1'b0; bus.ctrl_num_vec = '0;
        chk("t5_xrdy_2nd", bus.x_ready, 1'b1);
        bus.x_data = xdata(1);
        @(negedge clk);
        bus.x_valid = 1'b0; bus.x_data = '0;
        chk("t5_xrdy_after", bus.x_ready, 1'b0);
        chk("t5_busy", bus.ctrl_busy, 1'b1);
        feed_results(2);
        wait_done("t5");

        // Test 6: reset pulse mid-stream, then a clean job
        start_job(3);
        load_weights();
        stream_vecs(2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_busy",  bus.ctrl_busy,    1'b0);
        chk("t6_done",  bus.ctrl_done,    1'b0);
        chk("t6_start", bus.sys_start,    4'h0);
        chk("t6_data",  bus.sys_data,     '0);
        chk("t6_acc",   bus.sys_accept_w, 4'h0);
        chk("t6_wt",    bus.sys_weight,   '0);
        chk("t6_sw",    bus.sys_switch,   1'b0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.sys_start != 4'h0 || bus.ctrl_done) seen = 1'b1;
            @(negedge clk);
        end
        chk("t6_flushed", seen, 1'b0);
        start_job(1);
        load_weights();
        stream_vecs(1);
        feed_results(1);
        wait_done("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
